// File: rtl/fadd_align_if.sv
// Operand, result and shared-shifter signals of the FP16 add alignment controller.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// once valid is raised its payload is held stable until that transfer, and ready may not depend on valid.
interface fadd_align_if #(
  parameter int MW = 11,
  parameter int EW = 5,
  parameter int SW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   a;
  logic [15:0]   b;
  logic [MW-1:0] sh_in;
  logic [SW-1:0] sh_sel;
  logic [MW-1:0] sh_out;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] exp_out;
  logic          sign_big;
  logic          sign_small;
  logic [MW-1:0] mant_big;
  logic [MW-1:0] mant_small;
  logic          swap;
  logic          sticky;

  modport slave (
    input  in_valid, a, b, sh_out, out_ready,
    output in_ready, sh_in, sh_sel, out_valid, exp_out, sign_big, sign_small,
           mant_big, mant_small, swap, sticky
  );

  modport master (
    output in_valid, a, b, sh_out, out_ready,
    input  in_ready, sh_in, sh_sel, out_valid, exp_out, sign_big, sign_small,
           mant_big, mant_small, swap, sticky
  );
endinterface

// File: rtl/fadd_align_ctrl.sv
// Mantissa-alignment sequencer for the FP16 adder: IDLE -> CMP -> SHIFT -> DONE.
// Define FADD_ALIGN_STICKY_EN to build the sticky (shifted-out bits) output.
module fadd_align_ctrl #(
  parameter int MW    = 11,
  parameter int EW    = 5,
  parameter int SW    = 4,
  parameter int MAXSH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  fadd_align_if.slave      bus,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CMP   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [15:0]   a_r, b_r;
  logic          swap_r;
  logic          full_r;
  logic [SW-1:0] shamt_r;

  logic [EW-1:0] exp_q;
  logic          sign_big_q, sign_small_q, swap_q;
  logic [MW-1:0] mant_big_q, mant_small_q;

  // Denormals use an effective exponent of 1 and no hidden bit.
  logic [EW-1:0] ea, eb, e_big, diff_c;
  logic [MW-1:0] ma, mb, m_big, m_small;
  logic          b_gt;

  assign ea      = (a_r[14:10] == '0) ? EW'(1) : a_r[14:10];
  assign eb      = (b_r[14:10] == '0) ? EW'(1) : b_r[14:10];
  assign ma      = {|a_r[14:10], a_r[9:0]};
  assign mb      = {|b_r[14:10], b_r[9:0]};
  assign b_gt    = {eb, mb} > {ea, ma};
  assign diff_c  = b_gt ? (eb - ea) : (ea - eb);

  assign e_big   = swap_r ? eb : ea;
  assign m_big   = swap_r ? mb : ma;
  assign m_small = swap_r ? ma : mb;

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.sh_in      = (state == SHIFT) ? m_small : '0;
  assign bus.sh_sel     = (state == SHIFT) ? shamt_r : '0;
  assign bus.exp_out    = exp_q;
  assign bus.sign_big   = sign_big_q;
  assign bus.sign_small = sign_small_q;
  assign bus.mant_big   = mant_big_q;
  assign bus.mant_small = mant_small_q;
  assign bus.swap       = swap_q;
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_r          <= '0;
      b_r          <= '0;
      swap_r       <= 1'b0;
      full_r       <= 1'b0;
      shamt_r      <= '0;
      exp_q        <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swap_q       <= 1'b0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            state <= CMP;
          end
        end
        CMP: begin
          swap_r  <= b_gt;
          full_r  <= (diff_c >= EW'(MAXSH));
          shamt_r <= (diff_c >= EW'(MAXSH)) ? SW'(MAXSH) : diff_c[SW-1:0];
          state   <= SHIFT;
        end
        SHIFT: begin
          // A clamped shift must read as zero even if the shifter saturates differently.
          mant_small_q <= full_r ? '0 : bus.sh_out;
          mant_big_q   <= m_big;
          exp_q        <= e_big;
          sign_big_q   <= swap_r ? b_r[15] : a_r[15];
          sign_small_q <= swap_r ? a_r[15] : b_r[15];
          swap_q       <= swap_r;
          state        <= DONE;
        end
        default: begin
          if (bus.out_ready) state <= IDLE;
        end
      endcase
    end
  end

`ifdef FADD_ALIGN_STICKY_EN
  logic [MW-1:0] sticky_mask;
  logic          sticky_q;

  assign sticky_mask = (MW'(1) << shamt_r) - MW'(1);
  assign bus.sticky  = sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (state == SHIFT) begin
      sticky_q <= full_r ? (|m_small) : (|(m_small & sticky_mask));
    end
  end
`else
  assign bus.sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fadd_align_ctrl.sv
// Self-checking bench for fadd_align_ctrl: directed cases from the plan plus randomized pairs
// checked against a magnitude-based reference model.
module tb_fadd_align_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fadd_align_if bus ();
  logic [1:0] state_dbg;

  // Shared combinational right shifter.
  assign bus.sh_out = bus.sh_in >> bus.sh_sel;

  fadd_align_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [30:0] exp_q[$];
  logic [30:0] last_out;
  logic [3:0]  last_sel;
  logic [10:0] last_shin;

`ifdef FADD_ALIGN_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // {exp_out, sign_big, sign_small, mant_big, mant_small, swap, sticky}
  function automatic logic [30:0] act_pack();
    return {bus.exp_out, bus.sign_big, bus.sign_small, bus.mant_big, bus.mant_small,
            bus.swap, bus.sticky};
  endfunction

  // Reference: compare true magnitudes, align by integer division by 2^diff.
  task automatic model(input logic [15:0] av, input logic [15:0] bv,
                       output logic [30:0] res, output logic [3:0] sel,
                       output logic [10:0] shin);
    longint ea, eb, ma, mb, maga, magb, e_b, e_s, m_b, m_s, diff, dv, aligned;
    logic s_b, s_s, sw, st;
    ea = (av[14:10] == 5'd0) ? 1 : longint'(av[14:10]);
    eb = (bv[14:10] == 5'd0) ? 1 : longint'(bv[14:10]);
    ma = longint'(av[9:0]) + ((av[14:10] != 5'd0) ? 1024 : 0);
    mb = longint'(bv[9:0]) + ((bv[14:10] != 5'd0) ? 1024 : 0);
    maga = ma << (ea - 1);
    magb = mb << (eb - 1);
    sw = (magb > maga);
    e_b = sw ? eb : ea;  e_s = sw ? ea : eb;
    m_b = sw ? mb : ma;  m_s = sw ? ma : mb;
    s_b = sw ? bv[15] : av[15];
    s_s = sw ? av[15] : bv[15];
    diff = e_b - e_s;
    dv = longint'(1) << diff;
    aligned = m_s / dv;
    st = STICKY_ON && ((m_s % dv) != 0);
    res  = {e_b[4:0], s_b, s_s, m_b[10:0], aligned[10:0], sw, st};
    sel  = (diff > 11) ? 4'd11 : diff[3:0];
    shin = m_s[10:0];
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input int hold);
    logic [30:0] e;
    logic [3:0]  s;
    logic [10:0] si;
    model(av, bv, e, s, si);
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    bus.a = av; bus.b = bv; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    @(negedge clk);
    chk("cmp_sh_sel", bus.sh_sel, 0);
    chk("cmp_in_ready", bus.in_ready, 0);
    chk("cmp_out_valid", bus.out_valid, 0);
    @(negedge clk);
    last_sel = bus.sh_sel; last_shin = bus.sh_in;
    chk("shift_sh_sel", bus.sh_sel, s);
    chk("shift_sh_in", bus.sh_in, si);
    @(negedge clk);
    chk("latency_out_valid", bus.out_valid, 1);
    chk("done_sh_sel", bus.sh_sel, 0);
    last_out = act_pack();
    if (hold > 0) begin
      repeat (hold) begin
        bus.in_valid = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom);
        @(negedge clk);
        chk("hold_out_valid", bus.out_valid, 1);
        chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
  endtask

  // Every cycle a result is presented it must match the oldest expected pair.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
      else chk("result", act_pack(), exp_q[0]);
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [4:0]  ex;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sh_sel", bus.sh_sel, 0);
    chk("rst_sh_in", bus.sh_in, 0);
    chk("rst_outputs", act_pack(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 2.0: B larger, shift by one
    send(16'h3C00, 16'h4000, 0);
    chk("t1_sel", last_sel, 1);
    chk("t1_shin", last_shin, 11'h400);
    chk("t1_exp", last_out[30:26], 16);
    chk("t1_mbig", last_out[23:13], 11'h400);
    chk("t1_msmall", last_out[12:2], 11'h200);
    chk("t1_swap", last_out[1], 1);
    chk("t1_sticky", last_out[0], 0);

    // 1.5 + 1.0: equal exponents
    send(16'h3E00, 16'h3C00, 0);
    chk("t2_sel", last_sel, 0);
    chk("t2_exp", last_out[30:26], 15);
    chk("t2_mbig", last_out[23:13], 11'h600);
    chk("t2_msmall", last_out[12:2], 11'h400);
    chk("t2_swap", last_out[1], 0);

    // Clamp: diff 15
    send(16'h7800, 16'h3C01, 0);
    chk("t3_sel", last_sel, 11);
    chk("t3_msmall", last_out[12:2], 0);
    chk("t3_sticky", last_out[0], STICKY_ON);

    // Denormal with backpressure
    send(16'h0001, 16'h0400, 5);
    chk("t4_sel", last_sel, 0);
    chk("t4_exp", last_out[30:26], 1);
    chk("t4_mbig", last_out[23:13], 11'h400);
    chk("t4_msmall", last_out[12:2], 11'h001);
    chk("t4_swap", last_out[1], 1);

    // Tie on identical magnitude keeps A as big
    send(16'hC200, 16'h4200, 0);
    chk("t5_swap", last_out[1], 0);
    chk("t5_signs", last_out[25:24], 2'b10);

    // Reset during SHIFT discards the pair
    @(negedge clk);
    bus.a = 16'h3C00; bus.b = 16'h4400; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_shift_sel", bus.sh_sel, 2);
    rst_n = 1'b0;
    #1;
    chk("rmid_out_valid", bus.out_valid, 0);
    chk("rmid_in_ready", bus.in_ready, 1);
    chk("rmid_sh_sel", bus.sh_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rmid_no_result", bus.out_valid, 0);
    end

    // Randomized pairs, exponents often close together
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        ex = 5'($urandom_range(0, 31));
        ra[14:10] = ex;
        rb[14:10] = 5'(int'(ex) + $urandom_range(0, 3) > 31 ? 31 : int'(ex) + $urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) rb = ra;
      send(ra, rb, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
